// File: rtl/fme_pkg.sv
// Shared types and constants for the fractional motion estimation sequencer.
package fme_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALF,
      SATD_H,
      QUAT,
      SATD_Q,
      OUT
   } fme_state_t;

   localparam int NCAND = 9;
   localparam int CENTRE_IDX = 4;

   localparam logic SATD_SEL_HALF = 1'b0;
   localparam logic SATD_SEL_QUAT = 1'b1;

endpackage

// File: rtl/fme_job_fifo.sv
// Synchronous job queue of integer-pel positions.
module fme_job_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Extra pointer bit tells full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/fme_sched.sv
// Job sequencer: half interp, half SATD, quarter gen, quarter SATD,
// with per-stage watchdogs and a valid/ready result record.
module fme_sched #(
   parameter int POS_W  = 8,
   parameter int IDX_W  = 4,
   parameter int NCAND  = fme_pkg::NCAND,
   parameter int QDEPTH = 4,
   parameter int TMO    = 255,
   parameter int TMO_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [POS_W-1:0] job_pos,
   output logic [POS_W-1:0] cur_pos,
   output logic             half_start,
   input  logic             half_done,
   output logic             satd_start,
   output logic             satd_sel,
   input  logic             satd_done,
   input  logic [IDX_W-1:0] satd_best,
   output logic             quat_en,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [POS_W-1:0] res_pos,
   output logic [IDX_W-1:0] res_half_best,
   output logic [IDX_W-1:0] res_quat_best,
   output logic             res_err,
   output logic             busy
);

   import fme_pkg::*;

   localparam logic [IDX_W-1:0] CTR = IDX_W'(CENTRE_IDX);

   fme_state_t       state;
   logic [TMO_W-1:0] wdog;
   logic [POS_W-1:0] fifo_rd;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             wdog_exp;
   logic             idx_bad;
   logic [IDX_W-1:0] idx_fix;

   assign job_ready = !fifo_full;
   assign pop       = (state == IDLE) && !fifo_empty;
   assign busy      = (state != IDLE) || !fifo_empty;
   assign wdog_exp  = (wdog == TMO_W'(TMO - 1));
   assign idx_bad   = (satd_best >= IDX_W'(NCAND));
   assign idx_fix   = idx_bad ? CTR : satd_best;

   fme_job_fifo #(
      .W     (POS_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (job_valid && job_ready),
      .wr_data (job_pos),
      .rd_en   (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wdog          <= '0;
         cur_pos       <= '0;
         half_start    <= 1'b0;
         satd_start    <= 1'b0;
         satd_sel      <= SATD_SEL_HALF;
         quat_en       <= 1'b0;
         res_valid     <= 1'b0;
         res_pos       <= '0;
         res_half_best <= '0;
         res_quat_best <= '0;
         res_err       <= 1'b0;
      end else begin
         half_start <= 1'b0;
         satd_start <= 1'b0;
         quat_en    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  cur_pos       <= fifo_rd;
                  res_pos       <= fifo_rd;
                  res_err       <= 1'b0;
                  // Centre is the fallback for any pass that never reports.
                  res_half_best <= CTR;
                  res_quat_best <= CTR;
                  half_start    <= 1'b1;
                  wdog          <= '0;
                  state         <= HALF;
               end
            end
            HALF: begin
               if (half_done) begin
                  satd_sel   <= SATD_SEL_HALF;
                  satd_start <= 1'b1;
                  wdog       <= '0;
                  state      <= SATD_H;
               end else if (wdog_exp) begin
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  wdog <= wdog + TMO_W'(1);
               end
            end
            SATD_H: begin
               if (satd_done) begin
                  res_half_best <= idx_fix;
                  if (idx_bad)
                     res_err <= 1'b1;
                  quat_en <= 1'b1;
                  state   <= QUAT;
               end else if (wdog_exp) begin
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  wdog <= wdog + TMO_W'(1);
               end
            end
            QUAT: begin
               satd_sel   <= SATD_SEL_QUAT;
               satd_start <= 1'b1;
               wdog       <= '0;
               state      <= SATD_Q;
            end
            SATD_Q: begin
               if (satd_done) begin
                  res_quat_best <= idx_fix;
                  if (idx_bad)
                     res_err <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else if (wdog_exp) begin
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  wdog <= wdog + TMO_W'(1);
               end
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fme_sched.md
Name: fme_sched

Overview:
- Job-level sequencer for the fractional motion estimation datapath.
- Accepts integer-pel positions into a small queue and runs each job through four steps in order: half-pel interpolation, half-pel SATD search, quarter-pel candidate generation, quarter-pel SATD search.
- One SATD engine is time-shared between the half and quarter passes through a select output.
- Per-stage watchdogs stop a hung datapath from stalling the pipe; each job returns one result record through a valid/ready handshake.

Parameters:
- POS_W, 8, width of pixel-position word
- IDX_W, 4, width of candidate index
- NCAND, 9, candidates per pass (3x3); valid indices are 0..NCAND-1; centre index is 4
- QDEPTH, 4, job FIFO depth (power of 2)
- TMO, 255, maximum cycles spent waiting on a single stage done
- TMO_W, 8, watchdog counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- job_valid  in  1  job request
- job_ready  out  1  queue can accept a job
- job_pos  in  POS_W  integer-pel position
- cur_pos  out  POS_W  position of the active job, driven to the datapath
- half_start  out  1  one-cycle start pulse to the half interpolator
- half_done  in  1  half interpolator finished
- satd_start  out  1  one-cycle start pulse to the shared SATD engine
- satd_sel  out  1  0 = half candidates, 1 = quarter candidates
- satd_done  in  1  SATD engine finished
- satd_best  in  IDX_W  best candidate index, valid while satd_done is high
- quat_en  out  1  one-cycle enable to the quarter generator
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_pos  out  POS_W  result position
- res_half_best  out  IDX_W  half-pass winner
- res_quat_best  out  IDX_W  quarter-pass winner
- res_err  out  1  timeout or illegal index occurred in this job
- busy  out  1  state is not IDLE, or the FIFO is non-empty

Behaviour:
- Reset (rst=1 sampled at a rising edge):
  - FIFO emptied; state = IDLE.
  - All pulse outputs, res_valid, res_err and busy = 0.
  - res_* data fields and cur_pos = 0; satd_sel = 0; watchdog = 0.
  - Reset overrides everything, including a job in flight or an unconsumed result. Done inputs arriving afterwards are ignored.
- Job FIFO:
  - job_ready = !full; no bypass path.
  - A push occurs when job_valid && job_ready at a clock edge.
  - Push and pop in the same cycle are both legal when the FIFO is neither full nor empty, and when it is empty only the push happens.
  - Pointers wrap modulo QDEPTH.
- State machine (all outputs registered):
  - IDLE: if the FIFO is non-empty, pop, latch cur_pos/res_pos, clear res_err, assert half_start next cycle, go to HALF.
  - HALF: wait for half_done. On half_done, go to SATD_H with satd_sel=0 and satd_start high for the first SATD_H cycle.
  - SATD_H: on satd_done, latch res_half_best, go to QUAT with quat_en high for exactly one cycle.
  - QUAT: one cycle only. Go to SATD_Q with satd_sel=1 and a satd_start pulse.
  - SATD_Q: on satd_done, latch res_quat_best, go to OUT. res_valid rises on the same edge that samples satd_done.
  - OUT: hold res_valid and all res_* fields stable until res_ready. On res_valid && res_ready, drop res_valid and go to IDLE. The next job cannot start before the following cycle.
- Watchdog:
  - Cleared on entry to HALF, SATD_H and SATD_Q; increments every cycle in those states.
  - Reaching TMO without the expected done: set res_err.
  - Every best index not yet latched for the job becomes 4 (centre).
  - The machine jumps directly to OUT; no further starts are issued for that job.
- Illegal index: satd_best >= NCAND when sampled → latch 4 instead and set res_err; sequencing continues normally.
- Done inputs arriving in a state that does not wait for them are ignored, with no error. A done in the same cycle as the watchdog expiring counts as success.
- satd_sel changes only at stage transitions and is stable for the whole SATD pass.
- Minimum job latency, with every done returned one cycle after its start: 8 cycles from the pop to res_valid.

Decomposition:
- Shared package fme_pkg: state enum (IDLE, HALF, SATD_H, QUAT, SATD_Q, OUT), CENTRE_IDX=4, NCAND, and SATD_SEL_HALF/SATD_SEL_QUAT constants.
- One sub-module: fme_job_fifo, a synchronous FIFO of POS_W x QDEPTH with full/empty outputs.

Test Plan:
- Single job, job_pos=8'h2A; half_done and satd_done responses 3 cycles after each start; satd_best 7 then 2 → one record: res_pos=2A, half=7, quat=2, err=0. Exactly one half_start, two satd_start (sel 0 then 1), one quat_en.
- Push 6 jobs back to back while the first stalls on half_done → job_ready drops after 4 are queued. All jobs complete in FIFO order with correct positions.
- half_done never asserted → after 255 cycles, record with half=4, quat=4, err=1; no satd_start issued; next job proceeds normally.
- satd_best=4'hB on the half pass → half=4, err=1, quarter pass still runs and its index is reported.
- res_ready held low for 20 cycles → res_valid and fields stable, no new half_start. Release → IDLE, next job starts one cycle later.
- rst asserted during SATD_Q with 2 jobs queued → all outputs 0 next cycle, FIFO empty. A late satd_done produces no result.
